// File: rtl/sync_fifo_ram_if.sv
// Bus bundle for sync_fifo_ram: write/read requests, flush, read data and
// the occupancy/error status. The producer/consumer side uses the master
// modport. The FIFO itself uses the slave modport.
//
// Handshake: a request (we or re) is accepted in the cycle where it is
// high at a rising clock edge and the FIFO can take it. re is accepted
// when the FIFO is not empty. we is accepted when the FIFO is not full,
// or when a read is accepted in the same cycle. A refused request is
// dropped, not held, and sets the matching sticky error flag. Read data
// arrives on q one cycle after an accepted re, marked by q_valid.
// Requests made in the same cycle as flush are ignored.
interface sync_fifo_ram_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   logic                  flush;
   logic [DATA_WIDTH-1:0] data;
   logic                  we;
   logic                  re;
   logic [DATA_WIDTH-1:0] q;
   logic                  q_valid;
   logic [ADDR_WIDTH:0]   used;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, data, we, re,
      input  q, q_valid, used, full, empty,
      input  almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  flush, data, we, re,
      output q, q_valid, used, full, empty,
      output almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO built on an inferred simple dual-port RAM.
// It provides occupancy tracking, almost-full and almost-empty thresholds,
// flush, and sticky overflow/underflow flags. Read data is registered and
// has a latency of one cycle.
module sync_fifo_ram #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int ALMOST_FULL  = 56,
   parameter int ALMOST_EMPTY = 4
) (
   input logic              clock,
   input logic              reset,
   sync_fifo_ram_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Levels sized to the occupancy counter, so every compare has matching widths.
   localparam logic [ADDR_WIDTH:0] USED_MAX = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_FULL);
   localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   used_r;
   logic [ADDR_WIDTH:0]   used_nxt;
   logic [DATA_WIDTH-1:0] q_r;
   logic                  q_valid_r;
   logic                  overflow_r;
   logic                  underflow_r;

   logic full_w;
   logic empty_w;
   logic rd_ok;
   logic wr_ok;

   // Status flags decode from the registered occupancy only.
   always_comb begin
      full_w  = (used_r == USED_MAX);
      empty_w = (used_r == '0);
   end

   // Accept logic. A write into a full FIFO goes through only when a read
   // frees a slot in the same cycle. Flush masks both requests.
   always_comb begin
      rd_ok = bus.re & ~empty_w & ~bus.flush;
      wr_ok = bus.we & (~full_w | rd_ok) & ~bus.flush;
   end

   // Next occupancy. A read and a write in the same cycle cancel out.
   always_comb begin
      used_nxt = used_r;
      if (wr_ok && !rd_ok) begin
         used_nxt = used_r + 1'b1;
      end else if (rd_ok && !wr_ok) begin
         used_nxt = used_r - 1'b1;
      end
   end

   // RAM write port. The array has no reset, so reset and flush leave its contents.
   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem[wr_ptr] <= bus.data;
      end
   end

   // Pointers and occupancy. Flush returns them to zero, like reset does.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used_r <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used_r <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         used_r <= used_nxt;
      end
   end

   // Registered read port. q keeps its last word when no read is accepted.
   // q_valid marks the cycle after an accepted read.
   always_ff @(posedge clock) begin
      if (reset) begin
         q_r       <= '0;
         q_valid_r <= 1'b0;
      end else begin
         if (rd_ok) begin
            q_r <= mem[rd_ptr];
         end
         q_valid_r <= rd_ok;
      end
   end

   // Sticky error flags. Only reset clears them, and requests made during flush are not errors.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (bus.we && !wr_ok && !bus.flush) begin
            overflow_r <= 1'b1;
         end
         if (bus.re && !rd_ok && !bus.flush) begin
            underflow_r <= 1'b1;
         end
      end
   end

   // Output mapping onto the bus.
   always_comb begin
      bus.q            = q_r;
      bus.q_valid      = q_valid_r;
      bus.used         = used_r;
      bus.full         = full_w;
      bus.empty        = empty_w;
      bus.almost_full  = (used_r >= AF_LEVEL);
      bus.almost_empty = (used_r <= AE_LEVEL);
      bus.overflow     = overflow_r;
      bus.underflow    = underflow_r;
   end
endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed testbench for sync_fifo_ram (8 x 64, thresholds 56/4).
// Every step drives its inputs one time unit after a rising edge, then
// checks the outputs one time unit after the next rising edge.
module tb_sync_fifo_ram;
   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [7:0] wd;

   sync_fifo_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

   sync_fifo_ram #(
      .DATA_WIDTH(8), .ADDR_WIDTH(6), .ALMOST_FULL(56), .ALMOST_EMPTY(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Clock and reset block.
   always #5 clock = ~clock;

   // Compare one observed value against the expected value and record the result.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver: apply one cycle of requests, then release them after the edge.
   task automatic step(input logic w, input logic r, input logic f, input logic [7:0] d);
      bus.we    = w;
      bus.re    = r;
      bus.flush = f;
      bus.data  = d;
      @(posedge clock);
      #1;
      bus.we    = 1'b0;
      bus.re    = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic do_reset(input logic r);
      reset  = 1'b1;
      bus.re = r;
      @(posedge clock);
      #1;
      reset  = 1'b0;
      bus.re = 1'b0;
   endtask

   initial begin
      bus.we = 1'b0; bus.re = 1'b0; bus.flush = 1'b0; bus.data = '0;
      @(posedge clock);
      #1;
      do_reset(1'b0);

      // Reset state
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_used", 32'(bus.used), 0);
      chk("rst_q", 32'(bus.q), 0);
      chk("rst_qv", 32'(bus.q_valid), 0);
      chk("rst_ae", 32'(bus.almost_empty), 1);
      chk("rst_af", 32'(bus.almost_full), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_udf", 32'(bus.underflow), 0);

      // 1. Read while empty
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t1_empty", 32'(bus.empty), 1);
      chk("t1_qv", 32'(bus.q_valid), 0);
      chk("t1_udf", 32'(bus.underflow), 1);
      chk("t1_used", 32'(bus.used), 0);
      chk("t1_q", 32'(bus.q), 0);

      // 2. Fill with 0x00..0x3F, then overflow
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(i));
         chk("t2_used", 32'(bus.used), 32'(i + 1));
         chk("t2_af", 32'(bus.almost_full), (i + 1 >= 56) ? 32'd1 : 32'd0);
         chk("t2_full", 32'(bus.full), (i == 63) ? 32'd1 : 32'd0);
      end
      chk("t2_ovf_before", 32'(bus.overflow), 0);
      step(1'b1, 1'b0, 1'b0, 8'h99);
      chk("t2_ovf", 32'(bus.overflow), 1);
      chk("t2_used_hold", 32'(bus.used), 64);

      // 3. Write and read together while full, then drain
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      chk("t3_used", 32'(bus.used), 64);
      chk("t3_q", 32'(bus.q), 8'h00);
      chk("t3_qv", 32'(bus.q_valid), 1);
      for (int k = 0; k < 64; k++) begin
         step(1'b0, 1'b1, 1'b0, 8'h00);
         chk("t3_drain_q", 32'(bus.q), (k == 63) ? 32'hAA : 32'(k + 1));
         chk("t3_drain_used", 32'(bus.used), 32'(63 - k));
         chk("t3_drain_ae", 32'(bus.almost_empty), (63 - k <= 4) ? 32'd1 : 32'd0);
      end
      chk("t3_empty", 32'(bus.empty), 1);

      // Reset with a read in the same cycle: no q_valid, q cleared
      step(1'b1, 1'b0, 1'b0, 8'h12);
      do_reset(1'b1);
      chk("rst_mid_qv", 32'(bus.q_valid), 0);
      chk("rst_mid_used", 32'(bus.used), 0);
      chk("rst_mid_q", 32'(bus.q), 0);
      chk("rst_mid_ovf", 32'(bus.overflow), 0);

      // 4. Wrap: alternate writes and reads, at most one word in flight
      for (int i = 0; i < 100; i++) begin
         wd = 8'((i * 37 + 11) & 8'hFF);
         step(1'b1, 1'b0, 1'b0, wd);
         exp_q.push_back(wd);
         chk("t4_w_used", 32'(bus.used), 1);
         chk("t4_w_empty", 32'(bus.empty), 0);
         step(1'b0, 1'b1, 1'b0, 8'h00);
         chk("t4_r_q", 32'(bus.q), 32'(exp_q.pop_front()));
         chk("t4_r_used", 32'(bus.used), 0);
         chk("t4_r_empty", 32'(bus.empty), 1);
      end
      // Write and read together with one word stored returns the old word
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      step(1'b1, 1'b1, 1'b0, 8'hC3);
      chk("t4_rw1_q", 32'(bus.q), 8'h3C);
      chk("t4_rw1_used", 32'(bus.used), 1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t4_rw1_q2", 32'(bus.q), 8'hC3);
      chk("t4_ovf", 32'(bus.overflow), 0);
      chk("t4_udf", 32'(bus.underflow), 0);

      // 5. Flush with a write and a read in the same cycle
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      end
      chk("t5_used10", 32'(bus.used), 10);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      chk("t5_used", 32'(bus.used), 0);
      chk("t5_empty", 32'(bus.empty), 1);
      chk("t5_qv", 32'(bus.q_valid), 0);
      chk("t5_q_hold", 32'(bus.q), 8'hC3);
      chk("t5_ovf", 32'(bus.overflow), 0);
      chk("t5_udf", 32'(bus.underflow), 0);
      step(1'b1, 1'b0, 1'b0, 8'h55);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t5_q55", 32'(bus.q), 8'h55);
      chk("t5_qv55", 32'(bus.q_valid), 1);

      // 6. Threshold edges
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(i));
      end
      chk("t6_used5", 32'(bus.used), 5);
      chk("t6_ae5", 32'(bus.almost_empty), 0);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t6_used4", 32'(bus.used), 4);
      chk("t6_ae4", 32'(bus.almost_empty), 1);
      for (int i = 0; i < 51; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'(i));
      end
      chk("t6_used55", 32'(bus.used), 55);
      chk("t6_af55", 32'(bus.almost_full), 0);
      step(1'b1, 1'b0, 1'b0, 8'hEE);
      chk("t6_used56", 32'(bus.used), 56);
      chk("t6_af56", 32'(bus.almost_full), 1);
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk("t6_af_back", 32'(bus.almost_full), 0);
      chk("t6_ovf", 32'(bus.overflow), 0);
      chk("t6_udf", 32'(bus.underflow), 0);

      // Final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
